// File: rtl/bridge_pkg.sv
// Shared constants and the sequencer state type for the bridge.
package bridge_pkg;

  localparam int AW = 30;  // word address width (byte address bits [31:2])
  localparam int DW = 32;  // data width
  localparam int IW = 3;   // device index width, enough for 8 devices
  localparam int CW = 8;   // timeout counter width, enough for TIMEOUT up to 255

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bridge_decode.sv
// Address decoder: compares a word address against every device range
// (BASE..BASE+LAST inclusive) and reports the lowest-index match.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int                   NDEV = 2,
  parameter logic [NDEV*AW-1:0]   BASE = {AW'(32'h7f10 >> 2), AW'(32'h7f00 >> 2)},
  parameter logic [NDEV*3-1:0]    LAST = {3'd2, 3'd2}
) (
  input  logic [AW-1:0]   a,
  output logic            hit,
  output logic [NDEV-1:0] match,
  output logic [IW-1:0]   idx,
  output logic [AW-1:0]   off
);

  logic [NDEV-1:0] in_rng;

  // Per-device closed range compare.
  always_comb begin
    in_rng = '0;
    for (int i = 0; i < NDEV; i++) begin
      in_rng[i] = (a >= BASE[i*AW +: AW]) &&
                  (a <= BASE[i*AW +: AW] + AW'(LAST[i*3 +: 3]));
    end
  end

  // Priority select: walking downwards lets the lowest index overwrite last.
  always_comb begin
    hit   = |in_rng;
    match = '0;
    idx   = '0;
    off   = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (in_rng[i]) begin
        match    = '0;
        match[i] = 1'b1;
        idx      = IW'(i);
        off      = a - BASE[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/bridge_n.sv
// CPU-to-device bridge: decodes a word address onto one of NDEV devices,
// holds the access stable until the device acks or a timeout expires, then
// returns one cpu_rdy pulse with read data and an error flag.
// Handshake: cpu_req is only sampled in IDLE; cpu_rdy is a single-cycle pulse
// with cpu_rd/cpu_erq valid; dev_sel is held until dev_ack of the selected
// device is seen at a clock edge.
// The interrupt output is named intr because int is a reserved word.
module bridge_n
  import bridge_pkg::*;
#(
  parameter int                 NDEV    = 2,
  parameter logic [NDEV*AW-1:0] BASE    = {AW'(32'h7f10 >> 2), AW'(32'h7f00 >> 2)},
  parameter logic [NDEV*3-1:0]  LAST    = {3'd2, 3'd2},
  parameter logic [NDEV*3-1:0]  RO_OFF  = {3'd2, 3'd2},
  parameter int                 TIMEOUT = 15,
  parameter int                 NIRQ    = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic [31:2]          cpu_a,
  input  logic [DW-1:0]        cpu_wd,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_em,
  output logic                 cpu_hit,
  output logic                 cpu_rdy,
  output logic [DW-1:0]        cpu_rd,
  output logic                 cpu_erq,
  output logic [NDEV-1:0]      dev_sel,
  output logic [AW-1:0]        dev_off,
  output logic [DW-1:0]        dev_wd,
  output logic                 dev_we,
  input  logic [NDEV*DW-1:0]   dev_rd,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [NIRQ-1:0]      irq,
  output logic [5:0]           intr
);

  state_t          state_q, state_d;
  logic [NDEV-1:0] match;
  logic [IW-1:0]   idx, idx_q;
  logic [AW-1:0]   off, off_q;
  logic [DW-1:0]   wd_q, rd_q, rd_sel;
  logic            we_q, erq_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      ro_off;
  logic            start, imm_err, ack_sel, tmo;
  logic [NIRQ-1:0] sync1_q, sync2_q;

  bridge_decode #(
    .NDEV (NDEV),
    .BASE (BASE),
    .LAST (LAST)
  ) u_decode (
    .a     (cpu_a),
    .hit   (cpu_hit),
    .match (match),
    .idx   (idx),
    .off   (off)
  );

  // Next-state logic plus the per-cycle events the datapath acts on.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    imm_err = 1'b0;
    tmo     = 1'b0;
    ack_sel = 1'b0;
    rd_sel  = '0;
    ro_off  = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (match[i]) ro_off = RO_OFF[i*3 +: 3];
      if (idx_q == IW'(i)) begin
        ack_sel = dev_ack[i];
        rd_sel  = dev_rd[i*DW +: DW];
      end
    end
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if ((cpu_em != 2'd0) || !cpu_hit || (cpu_we && (off == AW'(ro_off)))) begin
            imm_err = 1'b1;
            state_d = DONE;
          end else begin
            start   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (ack_sel) begin
          state_d = DONE;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Access latches, timeout counter and completion data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      off_q <= '0;
      wd_q  <= '0;
      we_q  <= 1'b0;
      cnt_q <= '0;
      erq_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      if (start) begin
        idx_q <= idx;
        off_q <= off;
        wd_q  <= cpu_wd;
        we_q  <= cpu_we;
        cnt_q <= '0;
      end
      if (imm_err) erq_q <= 1'b1;
      if (state_q == WAIT) begin
        if (ack_sel) begin
          rd_q  <= rd_sel;
          erq_q <= 1'b0;
        end else if (tmo) begin
          rd_q  <= '0;
          erq_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // Device-side drive: only active while an access is outstanding.
  always_comb begin
    dev_sel = '0;
    if (state_q == WAIT) begin
      for (int i = 0; i < NDEV; i++) begin
        if (idx_q == IW'(i)) dev_sel[i] = 1'b1;
      end
    end
  end

  assign dev_off = off_q;
  assign dev_wd  = wd_q;
  assign dev_we  = we_q && (state_q == WAIT);
  assign cpu_rdy = (state_q == DONE);
  assign cpu_rd  = rd_q;
  assign cpu_erq = erq_q;

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  // Zero-extend the synchronised lines to the fixed 6-bit output.
  always_comb begin
    intr             = '0;
    intr[NIRQ-1:0]   = sync2_q;
  end

endmodule

// File: tb/tb_bridge_n.sv
// Bench for bridge_n: directed accesses, a device responder, and a monitor
// that pops expected completions whenever cpu_rdy is seen.
module tb_bridge_n;
  import bridge_pkg::*;

  localparam int NDEV = 2;
  localparam int W    = 66;  // {req_cyc16, lat8, nsel8, chk_rd, erq, rd32}

  logic              clk;
  logic              reset_n;
  logic              cpu_req;
  logic [31:2]       cpu_a;
  logic [31:0]       cpu_wd;
  logic              cpu_we;
  logic [1:0]        cpu_em;
  logic              cpu_hit, cpu_rdy, cpu_erq;
  logic [31:0]       cpu_rd;
  logic [NDEV-1:0]   dev_sel;
  logic [29:0]       dev_off;
  logic [31:0]       dev_wd;
  logic              dev_we;
  logic [NDEV*32-1:0] dev_rd;
  logic [NDEV-1:0]   dev_ack = '0;
  logic [5:0]        irq;
  logic [5:0]        intr;

  logic [W-1:0]      exp_q[$];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                ack_dev = 0;
  int                ack_delay = -1;
  int                wcnt = 0;
  int                run_len = 0;
  logic [NDEV-1:0]   exp_sel = '0;
  logic [29:0]       exp_off = '0;
  logic              exp_we = 1'b0;
  logic [31:0]       exp_wd = '0;

  assign dev_rd = {32'hA5A55A5A, 32'hDEADBEEF};

  bridge_n #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_req (cpu_req),
    .cpu_a   (cpu_a),
    .cpu_wd  (cpu_wd),
    .cpu_we  (cpu_we),
    .cpu_em  (cpu_em),
    .cpu_hit (cpu_hit),
    .cpu_rdy (cpu_rdy),
    .cpu_rd  (cpu_rd),
    .cpu_erq (cpu_erq),
    .dev_sel (dev_sel),
    .dev_off (dev_off),
    .dev_wd  (dev_wd),
    .dev_we  (dev_we),
    .dev_rd  (dev_rd),
    .dev_ack (dev_ack),
    .irq     (irq),
    .intr    (intr)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device responder: checks the held access and acks after ack_delay WAIT cycles.
  always @(posedge clk) begin
    #1;
    dev_ack = '0;
    if (dev_sel != '0) begin
      check("dev_sel", 64'(dev_sel), 64'(exp_sel));
      check("dev_off", 64'(dev_off), 64'(exp_off));
      check("dev_we",  64'(dev_we),  64'(exp_we));
      check("dev_wd",  64'(dev_wd),  64'(exp_wd));
      if (wcnt == ack_delay) dev_ack[ack_dev] = 1'b1;
      wcnt++;
    end else begin
      run_len = wcnt;
      wcnt    = 0;
    end
  end

  // Monitor: every cpu_rdy must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (cpu_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy: got cpu_rdy=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("latency",    64'(cyc - int'(e[65:50]) + 1), 64'(e[49:42]));
        check("sel_cycles", 64'(run_len), 64'(e[41:34]));
        check("erq",        64'(cpu_erq), 64'(e[32]));
        if (e[33]) check("rd", 64'(cpu_rd), 64'(e[31:0]));
      end
    end
  end

  // Driver: issue one request, push its expected completion, wait for it.
  task automatic run(input string name, input logic [31:2] a, input logic [31:0] wd,
                     input logic we, input logic [1:0] em, input int adev, input int adly,
                     input logic [NDEV-1:0] esel, input logic [29:0] eoff, input logic ehit,
                     input logic chk, input logic erq, input logic [31:0] rd,
                     input int lat, input int nsel);
    ack_dev   = adev;
    ack_delay = adly;
    exp_sel   = esel;
    exp_off   = eoff;
    exp_we    = we;
    exp_wd    = wd;
    cpu_a     = a;
    cpu_wd    = wd;
    cpu_we    = we;
    cpu_em    = em;
    cpu_req   = 1'b1;
    exp_q.push_back({16'(cyc), 8'(lat), 8'(nsel), chk, erq, rd});
    #1;
    check({name, "_hit"}, 64'(cpu_hit), 64'(ehit));
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_em  = 2'd0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_done: got no cpu_rdy within 40 cycles expected one", name);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0;
    cpu_a   = '0;
    cpu_wd  = '0;
    cpu_we  = 1'b0;
    cpu_em  = 2'd0;
    irq     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",  64'(cpu_rdy), 64'd0);
    check("rst_erq",  64'(cpu_erq), 64'd0);
    check("rst_rd",   64'(cpu_rd),  64'd0);
    check("rst_intr", 64'(intr),    64'd0);
    check("rst_sel",  64'(dev_sel), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    //   name       addr      wd            we  em adev adly esel   eoff hit chk erq rd            lat nsel
    run("rd_hit",   30'h1fc1, 32'h0,        0,  0, 0,   0,   2'b01, 1,   1,  1,  0,  32'hDEADBEEF, 3,  1);
    run("ro_wr1",   30'h1fc6, 32'h11,       1,  0, 1,   0,   2'b10, 2,   1,  0,  1,  32'h0,        2,  0);
    run("tmo",      30'h1fc4, 32'h0,        0,  0, 1,   -1,  2'b10, 0,   1,  1,  1,  32'h0,        6,  4);
    run("miss",     30'h0400, 32'h0,        0,  0, 0,   0,   2'b01, 0,   0,  0,  1,  32'h0,        2,  0);
    run("em",       30'h1fc0, 32'h0,        0,  1, 0,   0,   2'b01, 0,   1,  0,  1,  32'h0,        2,  0);
    run("wr0",      30'h1fc0, 32'h12345678, 1,  0, 0,   1,   2'b01, 0,   1,  1,  0,  32'hDEADBEEF, 4,  2);
    run("rd1_dly",  30'h1fc5, 32'h0,        0,  0, 1,   2,   2'b10, 1,   1,  1,  0,  32'hA5A55A5A, 5,  3);
    run("wrong_ack",30'h1fc5, 32'h0,        0,  0, 0,   0,   2'b10, 1,   1,  1,  1,  32'h0,        6,  4);
    run("ack_last", 30'h1fc2, 32'h0,        0,  0, 0,   3,   2'b01, 2,   1,  1,  0,  32'hDEADBEEF, 6,  4);
    run("gap_miss", 30'h1fc3, 32'h0,        0,  0, 0,   0,   2'b01, 0,   0,  0,  1,  32'h0,        2,  0);
    run("ro_wr0",   30'h1fc2, 32'h22,       1,  0, 0,   0,   2'b01, 2,   1,  0,  1,  32'h0,        2,  0);

    // Reset during the second WAIT cycle of a dev1 read.
    ack_dev   = 1;
    ack_delay = -1;
    exp_sel   = 2'b10;
    exp_off   = 30'd0;
    exp_we    = 1'b0;
    exp_wd    = 32'h0;
    cpu_a     = 30'h1fc4;
    cpu_wd    = 32'h0;
    cpu_we    = 1'b0;
    cpu_req   = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rstw_sel", 64'(dev_sel), 64'd0);
    check("rstw_rdy", 64'(cpu_rdy), 64'd0);
    check("rstw_rd",  64'(cpu_rd),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run("post_rst", 30'h1fc1, 32'h0, 0, 0, 0, 0, 2'b01, 1, 1, 1, 0, 32'hDEADBEEF, 3, 1);

    // Interrupt synchroniser.
    irq[2] = 1'b1;
    @(posedge clk); #1;
    check("int_1edge", 64'(intr), 64'h00);
    @(posedge clk); #1;
    check("int_2edge", 64'(intr), 64'h04);
    @(posedge clk); #1;
    check("int_hi",    64'(intr[5:3]), 64'h0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bridge_n.md
BRIDGE_N -- requirements
Module: bridge_n

Interface
REQ-001 SHALL have parameter NDEV, default 2: number of devices, 1..8.
REQ-002 SHALL have parameter BASE, default {'h7f10>>2, 'h7f00>>2}: NDEV x 30-bit packed word base addresses, device 0 in the LSBs.
REQ-003 SHALL have parameter LAST, default {3'd2, 3'd2}: NDEV x 3-bit packed last word offset; device range is BASE..BASE+LAST, closed.
REQ-004 SHALL have parameter RO_OFF, default {3'd2, 3'd2}: NDEV x 3-bit packed read-only word offset per device.
REQ-005 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before bus error, 1..255.
REQ-006 SHALL have parameter NIRQ, default 6: interrupt lines, 1..6.
REQ-007 SHALL have ports in this order: clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-008 SHALL have cpu_req in 1, request strobe sampled in IDLE; cpu_a in [31:2], word address; cpu_wd in 32, write data; cpu_we in 1, write; cpu_em in 2, upstream exception code.
REQ-009 SHALL have cpu_hit out 1 (combinational range decode of cpu_a), cpu_rdy out 1 (one-cycle completion), cpu_rd out 32 (read data), cpu_erq out 1 (error, valid with cpu_rdy).
REQ-010 SHALL have dev_sel out NDEV (one-hot), dev_off out 30, dev_wd out 32, dev_we out 1, dev_rd in NDEV*32, dev_ack in NDEV.
REQ-011 SHALL have irq in NIRQ and int out 6.

Function
REQ-012 SHALL decode cpu_a against every range; the lowest-index matching device wins; cpu_hit = any match.
REQ-013 SHALL use FSM IDLE -> WAIT -> DONE -> IDLE; cpu_req is ignored outside IDLE.
REQ-014 IDLE with cpu_req: flag an immediate error if cpu_em != 0, or miss, or (cpu_we and offset == RO_OFF of the hit device); on error go to DONE with erq latched 1 and no dev_sel.
REQ-015 IDLE with cpu_req and no error: latch device index, offset (cpu_a - BASE), cpu_wd and cpu_we; clear the timeout counter; go to WAIT.
REQ-016 In WAIT: assert dev_sel[idx]; drive the latched dev_off/dev_wd; drive dev_we = latched we; all are stable for the whole of WAIT.
REQ-017 In WAIT, dev_ack[idx] high at a clock edge: capture dev_rd[idx] into cpu_rd, erq = 0, go to DONE; acks from other devices are ignored.
REQ-018 In WAIT without ack: increment the counter; when it equals TIMEOUT, go to DONE with erq = 1 and cpu_rd = 0. An ack on the same cycle takes priority.
REQ-019 In DONE: cpu_rdy = 1 for exactly one cycle, cpu_rd/cpu_erq valid; next state is IDLE. cpu_rd holds until the next capture.
REQ-020 Latency: request to cpu_rdy is 2 cycles for an immediate error; 3 + (ack delay) cycles for an acked access; TIMEOUT + 2 cycles for a timeout.
REQ-021 Outside WAIT, dev_sel = 0 and dev_we = 0.
REQ-022 irq SHALL pass through a 2-flop synchroniser; int = {zeros, synced irq}; latency 2 cycles.

Reset
REQ-023 reset_n low SHALL asynchronously force: state IDLE, counter 0, cpu_rdy 0, cpu_erq 0, cpu_rd 0, latched fields 0, synchroniser flops 0, int 0.
REQ-024 Reset mid-WAIT SHALL drop dev_sel immediately; no cpu_rdy is ever produced for the aborted access.

Structure
REQ-025 Shared package bridge_pkg SHALL hold the FSM state typedef (IDLE/WAIT/DONE) and the address/data width constants.
REQ-026 The decode logic SHALL be one sub-module, bridge_decode (cpu_a -> hit, one-hot match, index, offset); the sequencer is in bridge_n.

Verification
REQ-027 Read hit: cpu_a = 'h7f04>>2, cpu_we = 0; dev_ack[0] in the first WAIT cycle with dev_rd[0] = 'hDEADBEEF -> dev_off = 1; cpu_rdy 3 cycles after the request; cpu_rd = 'hDEADBEEF; erq = 0.
REQ-028 Read-only write: cpu_a = 'h7f18>>2, cpu_we = 1 -> no dev_sel; cpu_rdy 2 cycles after the request with erq = 1.
REQ-029 Timeout: TIMEOUT = 4, dev_ack never asserted -> dev_sel[1] high for 4 cycles; cpu_rdy with erq = 1, cpu_rd = 0.
REQ-030 Miss and em: cpu_a = 'h1000>>2 -> erq = 1, cpu_hit = 0; cpu_em = 1 on a valid hit -> erq = 1, no dev_sel.
REQ-031 Reset in WAIT: pull reset_n low in the 2nd WAIT cycle -> dev_sel = 0 at once; no cpu_rdy; after release a new request completes normally.
REQ-032 Interrupts: irq[2] rises -> int[2] rises after 2 edges; int[5:3] stays 0.
